// File: rtl/alu_result_serializer.sv
// -----------------------------------------------------------------------------
// alu_result_serializer
//
// Takes each ALU result word and sends it to the UART TX path one byte at a
// time, least significant byte first, using a valid/ready handshake. One
// result is held as "active" (being sent) and one more can wait as "pending",
// so two results close together are both kept while TX is stalled.
//
// Parameters
//   Width            ALU result width. Must be a multiple of 8 and at least 8.
//
// Ports
//   clk_i            system clock; all logic runs on the rising edge
//   rst_i            asynchronous, active-high reset
//   alu_out_i        result word from the ALU stage
//   alu_valid_i      1 = alu_out_i holds a new result this cycle
//   tx_ready_i       TX consumer accepts tx_data_o this cycle
//   tx_data_o        byte to transmit
//   tx_valid_o       tx_data_o is valid; held until accepted
//   busy_o           a result is still being sent or is waiting
//   drop_pulse_o     one-cycle pulse: an incoming result was thrown away
//
// Configuration macro
//   ALU_SER_CHECKSUM_EN  When defined, each result is followed by one extra
//                        byte: the XOR of all its data bytes.
//
// States
//   IDLE | nothing to send, tx_valid_o = 0
//   SEND | sending data byte byte_idx_q of the active result
//   CHK  | sending the XOR checksum byte (ALU_SER_CHECKSUM_EN only)
// -----------------------------------------------------------------------------
module alu_result_serializer #(
  parameter int Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] alu_out_i,
  input  logic             alu_valid_i,
  input  logic             tx_ready_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  output logic             busy_o,
  output logic             drop_pulse_o
);

  localparam int NUM_BYTES = Width / 8;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
`ifdef ALU_SER_CHECKSUM_EN
    , CHK = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [Width-1:0] active_q, active_d;
  logic [Width-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;

  logic             hs;
  logic             done;

  function automatic logic [7:0] byte_sel(input logic [Width-1:0] w,
                                          input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (idx == IDX_W'(i)) b = w[i*8 +: 8];
    end
    return b;
  endfunction

`ifdef ALU_SER_CHECKSUM_EN
  function automatic logic [7:0] xor_bytes(input logic [Width-1:0] w);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      x = x ^ w[i*8 +: 8];
    end
    return x;
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    byte_idx_d  = byte_idx_q;
    drop_d      = 1'b0;
    done        = 1'b0;
    // tx_ready_i is only meaningful while a byte is actually offered.
    hs          = tx_valid_q & tx_ready_i;

    unique case (state_q)
      IDLE: begin
        if (alu_valid_i) begin
          active_d   = alu_out_i;
          byte_idx_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (byte_idx_q != LAST_IDX) begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end else begin
`ifdef ALU_SER_CHECKSUM_EN
            state_d = CHK;
`else
            done = 1'b1;
`endif
          end
        end
      end
`ifdef ALU_SER_CHECKSUM_EN
      CHK: begin
        if (hs) done = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    // While busy, the result just finished is replaced straight away so that
    // tx_valid_o does not drop between results. The pending slot is older
    // than anything arriving now, so it goes first.
    if (state_q != IDLE) begin
      if (done) begin
        byte_idx_d = '0;
        if (pend_full_q) begin
          active_d = pend_q;
          state_d  = SEND;
          if (alu_valid_i) begin
            pend_d = alu_out_i;
          end else begin
            pend_full_d = 1'b0;
          end
        end else if (alu_valid_i) begin
          active_d = alu_out_i;
          state_d  = SEND;
        end else begin
          state_d = IDLE;
        end
      end else if (alu_valid_i) begin
        if (!pend_full_q) begin
          pend_d      = alu_out_i;
          pend_full_d = 1'b1;
        end else begin
          drop_d = 1'b1;
        end
      end
    end

    tx_data_d = tx_data_q;
    unique case (state_d)
      SEND:    tx_data_d = byte_sel(active_d, byte_idx_d);
`ifdef ALU_SER_CHECKSUM_EN
      CHK:     tx_data_d = xor_bytes(active_d);
`endif
      default: tx_data_d = tx_data_q;
    endcase

    tx_valid_d = (state_d != IDLE);
    busy_d     = (state_d != IDLE) | pend_full_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      byte_idx_q  <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      byte_idx_q  <= byte_idx_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
    end
  end

  assign tx_data_o    = tx_data_q;
  assign tx_valid_o   = tx_valid_q;
  assign busy_o       = busy_q;
  assign drop_pulse_o = drop_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
module tb_alu_result_serializer;

  localparam int W = 16;
`ifdef ALU_SER_CHECKSUM_EN
  localparam int FRAME = 3;
`else
  localparam int FRAME = 2;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] alu_out;
  logic         alu_valid;
  logic         tx_ready;
  logic [7:0]   tx_data_o;
  logic         tx_valid_o;
  logic         busy_o;
  logic         drop_pulse_o;

  int checks;
  int failures;

  alu_result_serializer #(.Width(W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .alu_out_i    (alu_out),
    .alu_valid_i  (alu_valid),
    .tx_ready_i   (tx_ready),
    .tx_data_o    (tx_data_o),
    .tx_valid_o   (tx_valid_o),
    .busy_o       (busy_o),
    .drop_pulse_o (drop_pulse_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits up to max_wait cycles (with tx_ready=1) for the next offered byte.
  task automatic recv_byte(input int max_wait, output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = '0;
    tx_ready = 1'b1;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (tx_valid_o === 1'b1) begin
        b  = tx_data_o;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; alu_valid = 1'b0; alu_out = '0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (tx_valid_o !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid_o); end
    checks++; if (tx_data_o !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (drop_pulse_o !== 1'b0) begin failures++; $display("FAIL reset_drop got=%b exp=0", drop_pulse_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] e [FRAME];
    logic [7:0] b;
    bit ok;
`ifdef ALU_SER_CHECKSUM_EN
    e = '{8'h5A, 8'hA5, 8'hFF};
`else
    e = '{8'h5A, 8'hA5};
`endif
    tx_ready = 1'b1; alu_out = 16'hA55A; alu_valid = 1'b1;
    @(negedge clk);
    alu_valid = 1'b0;
    checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== e[0]) begin failures++; $display("FAIL basic_latency got=%b/%h exp=1/%h", tx_valid_o, tx_data_o, e[0]); end
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy_o); end
    for (int k = 1; k < FRAME; k++) begin
      recv_byte(1, b, ok);
      checks++; if (!ok || b !== e[k]) begin failures++; $display("FAIL basic_byte%0d got=%h ok=%0d exp=%h", k, b, ok, e[k]); end
    end
    @(negedge clk);
    checks++; if (tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL basic_end valid/busy got=%b/%b exp=0/0", tx_valid_o, busy_o); end
  endtask

  task automatic test_stall;
    logic [7:0] e [FRAME];
    logic [7:0] b;
    bit ok;
`ifdef ALU_SER_CHECKSUM_EN
    e = '{8'h5A, 8'hA5, 8'hFF};
`else
    e = '{8'h5A, 8'hA5};
`endif
    tx_ready = 1'b0; alu_out = 16'hA55A; alu_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      alu_valid = 1'b0;
      checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h5A) begin failures++; $display("FAIL stall_hold%0d got=%b/%h exp=1/5a", i, tx_valid_o, tx_data_o); end
    end
    for (int k = 1; k < FRAME; k++) begin
      recv_byte(1, b, ok);
      checks++; if (!ok || b !== e[k]) begin failures++; $display("FAIL stall_byte%0d got=%h ok=%0d exp=%h", k, b, ok, e[k]); end
    end
    @(negedge clk);
    checks++; if (tx_valid_o !== 1'b0) begin failures++; $display("FAIL stall_end got=%b exp=0", tx_valid_o); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] e [2*FRAME];
    logic [7:0] b;
    bit ok;
`ifdef ALU_SER_CHECKSUM_EN
    e = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h00, 8'h02};
`else
    e = '{8'h01, 8'h00, 8'h02, 8'h00};
`endif
    tx_ready = 1'b0; alu_out = 16'h0001; alu_valid = 1'b1;
    @(negedge clk);
    alu_out = 16'h0002;
    @(negedge clk);
    checks++; if (drop_pulse_o !== 1'b0) begin failures++; $display("FAIL b2b_nodrop_early got=%b exp=0", drop_pulse_o); end
    alu_out = 16'h0003;
    @(negedge clk);
    alu_valid = 1'b0;
    checks++; if (drop_pulse_o !== 1'b1) begin failures++; $display("FAIL b2b_drop got=%b exp=1", drop_pulse_o); end
    @(negedge clk);
    checks++; if (drop_pulse_o !== 1'b0) begin failures++; $display("FAIL b2b_drop_width got=%b exp=0", drop_pulse_o); end
    checks++; if (busy_o !== 1'b1 || tx_data_o !== e[0]) begin failures++; $display("FAIL b2b_first busy/data got=%b/%h exp=1/%h", busy_o, tx_data_o, e[0]); end
    tx_ready = 1'b1;
    for (int k = 1; k < 2*FRAME; k++) begin
      recv_byte(1, b, ok);
      checks++; if (!ok || b !== e[k]) begin failures++; $display("FAIL b2b_byte%0d got=%h ok=%0d exp=%h", k, b, ok, e[k]); end
    end
    @(negedge clk);
    checks++; if (tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL b2b_end valid/busy got=%b/%b exp=0/0", tx_valid_o, busy_o); end
  endtask

  task automatic test_reload_same_cycle;
    logic [7:0] e [FRAME];
    logic [7:0] b;
    bit ok;
`ifdef ALU_SER_CHECKSUM_EN
    e = '{8'h78, 8'h56, 8'h2E};
`else
    e = '{8'h78, 8'h56};
`endif
    tx_ready = 1'b1; alu_out = 16'h5678; alu_valid = 1'b1;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      alu_valid = 1'b0;
      checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== e[k]) begin failures++; $display("FAIL reload_byte%0d got=%b/%h exp=1/%h", k, tx_valid_o, tx_data_o, e[k]); end
      if (k == FRAME - 1) begin
        alu_out = 16'h1234; alu_valid = 1'b1;
      end
    end
    @(negedge clk);
    alu_valid = 1'b0;
    checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h34) begin failures++; $display("FAIL reload_start got=%b/%h exp=1/34", tx_valid_o, tx_data_o); end
    checks++; if (drop_pulse_o !== 1'b0) begin failures++; $display("FAIL reload_nodrop got=%b exp=0", drop_pulse_o); end
    recv_byte(1, b, ok);
    checks++; if (!ok || b !== 8'h12) begin failures++; $display("FAIL reload_byte_hi got=%h ok=%0d exp=12", b, ok); end
`ifdef ALU_SER_CHECKSUM_EN
    recv_byte(1, b, ok);
    checks++; if (!ok || b !== 8'h26) begin failures++; $display("FAIL reload_chk got=%h ok=%0d exp=26", b, ok); end
`endif
    @(negedge clk);
    checks++; if (tx_valid_o !== 1'b0) begin failures++; $display("FAIL reload_end got=%b exp=0", tx_valid_o); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] b;
    bit ok;
    bit idle_ok;
    tx_ready = 1'b1; alu_out = 16'hA55A; alu_valid = 1'b1;
    @(negedge clk);
    alu_valid = 1'b0;
    checks++; if (tx_data_o !== 8'h5A) begin failures++; $display("FAIL rstmid_byte0 got=%h exp=5a", tx_data_o); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_async valid/busy got=%b/%b exp=0/0", tx_valid_o, busy_o); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (tx_valid_o !== 1'b0 || busy_o !== 1'b0) idle_ok = 1'b0;
    end
    checks++; if (!idle_ok) begin failures++; $display("FAIL rstmid_idle got=replayed_activity exp=idle"); end
    alu_out = 16'hBEEF; alu_valid = 1'b1;
    @(negedge clk);
    alu_valid = 1'b0;
    checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'hEF) begin failures++; $display("FAIL rstmid_new got=%b/%h exp=1/ef", tx_valid_o, tx_data_o); end
    recv_byte(1, b, ok);
    checks++; if (!ok || b !== 8'hBE) begin failures++; $display("FAIL rstmid_new_hi got=%h ok=%0d exp=be", b, ok); end
`ifdef ALU_SER_CHECKSUM_EN
    recv_byte(1, b, ok);
    checks++; if (!ok || b !== 8'h51) begin failures++; $display("FAIL rstmid_new_chk got=%h ok=%0d exp=51", b, ok); end
`endif
    @(negedge clk);
    checks++; if (tx_valid_o !== 1'b0) begin failures++; $display("FAIL rstmid_end got=%b exp=0", tx_valid_o); end
  endtask

  function automatic logic [7:0] frame_byte(input logic [W-1:0] w, input int pos);
    if (pos == 0) return w[7:0];
    if (pos == 1) return w[15:8];
    return w[7:0] ^ w[15:8];
  endfunction

  task automatic test_random;
    logic [W-1:0] q[$];
    int  bpos;
    bit  exp_drop;
    bit  v, r, hs, comp, accept;
    logic [W-1:0] word;
    int  fails_before;
    bpos = 0; exp_drop = 1'b0;
    fails_before = failures;
    for (int cyc = 0; cyc < 10020; cyc++) begin
      @(negedge clk);
      checks++; if (drop_pulse_o !== exp_drop) begin failures++; $display("FAIL rand_drop cyc=%0d got=%b exp=%b", cyc, drop_pulse_o, exp_drop); end
      checks++; if (tx_valid_o !== (q.size() != 0)) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, tx_valid_o, (q.size() != 0)); end
      checks++; if (busy_o !== (q.size() != 0)) begin failures++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy_o, (q.size() != 0)); end
      if (q.size() != 0) begin
        checks++; if (tx_data_o !== frame_byte(q[0], bpos)) begin failures++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, tx_data_o, frame_byte(q[0], bpos)); end
      end
      if (failures - fails_before > 20) begin
        $display("FAIL rand_abort too many errors at cyc=%0d", cyc);
        break;
      end
      v    = (cyc < 10000) ? ($urandom_range(0, 99) < 45) : 1'b0;
      r    = (cyc < 10000) ? ($urandom_range(0, 99) < 60) : 1'b1;
      word = W'($urandom);
      hs   = (tx_valid_o === 1'b1) && r && (q.size() != 0);
      comp = 1'b0;
      if (hs) begin
        bpos++;
        if (bpos == FRAME) begin bpos = 0; comp = 1'b1; end
      end
      accept   = v && ((q.size() < 2) || comp);
      exp_drop = v && !accept;
      if (comp) void'(q.pop_front());
      if (accept) q.push_back(word);
      alu_valid = v; tx_ready = r; alu_out = word;
    end
    alu_valid = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; alu_valid = 1'b0; alu_out = '0; tx_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reload_same_cycle();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
